// File: rtl/multi_clk_divider.sv
// Multi-channel programmable clock divider. Each channel produces a registered
// 50% duty divided clock plus a one-cycle tick on every rising edge. Half-periods
// are double-buffered: a new value is held in a shadow register and takes effect
// only at a terminal count or while the channel is stopped.
module multi_clk_divider #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = 22,
  parameter int unsigned DEFAULT_DIV = 1_250_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              div_wr,
  input  logic [2:0]        div_ch,
  input  logic [CNT_W-1:0]  div_val,
  input  logic [NUM_CH-1:0] en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] running
);

  typedef enum logic {StStopped = 1'b0, StRun = 1'b1} state_e;

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] half;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wr_hit;
    logic             tc;

    // div_ch values at or above NUM_CH never match any channel, so they are dropped.
    assign wr_hit = div_wr && (div_ch == 3'(g));
    // A programmed half-period of 0 behaves as 1.
    assign half   = (active_q == '0) ? CNT_W'(1) : active_q;
    assign tc     = (state_q == StRun) && (cnt_q == half - CNT_W'(1));

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= StStopped;
        cnt_q    <= '0;
        shadow_q <= DefDiv;
        active_q <= DefDiv;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        shadow_q <= shadow_d;
        active_q <= active_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
      end
    end

    // Next state: a stop request waits for the high phase to finish at TC.
    always_comb begin
      state_d = state_q;
      case (state_q)
        StStopped: if (en[g]) state_d = StRun;
        StRun:     if (!en[g] && (!clk_q || tc)) state_d = StStopped;
        default:   state_d = StStopped;
      endcase
    end

    // Datapath next values: counter, toggle, tick and divisor buffering.
    always_comb begin
      cnt_d    = cnt_q;
      clk_d    = clk_q;
      tick_d   = 1'b0;
      shadow_d = wr_hit ? div_val : shadow_q;
      active_d = active_q;
      // shadow_d already carries a same-cycle write, giving the write bypass.
      if ((state_q == StStopped) || tc) active_d = shadow_d;
      case (state_q)
        StStopped: begin
          cnt_d = '0;
          clk_d = 1'b0;
        end
        StRun: begin
          if (!en[g] && !clk_q) begin
            cnt_d = '0;
          end else if (tc) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = ~clk_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d = '0;
          clk_d = 1'b0;
        end
      endcase
    end

    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
    assign running[g] = (state_q == StRun);
  end

endmodule
